// File: rtl/sprite_hit_pipe.sv
// Two-stage pipelined hit tester for N fixed-size sprites on the VGA raster.
// Positions are written to a shadow table and copied to the active table on frame_sync.
module sprite_hit_pipe #(
  parameter  int N_SPR   = 4,
  parameter  int SPR_W   = 50,
  parameter  int SPR_H   = 40,
  parameter  int COORD_W = 10,
  localparam int IDX_W   = $clog2(N_SPR),
  localparam int ADDR_W  = $clog2(SPR_W*SPR_H)
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               pos_we,
  input  logic [IDX_W-1:0]   pos_idx,
  input  logic [COORD_W:0]   pos_left,
  input  logic [COORD_W:0]   pos_upper,
  input  logic               pos_vis,
  input  logic               frame_sync,
  input  logic               pix_valid,
  input  logic [COORD_W-1:0] DrawX,
  input  logic [COORD_W-1:0] DrawY,
  output logic               out_valid,
  output logic               hit,
  output logic [IDX_W-1:0]   hit_idx,
  output logic [ADDR_W-1:0]  addra
);

  localparam int DIFF_W = COORD_W + 2;
  localparam int DX_W   = $clog2(SPR_W);
  localparam int DY_W   = $clog2(SPR_H);

  logic signed [COORD_W:0] r_sh_left  [N_SPR];
  logic signed [COORD_W:0] r_sh_upper [N_SPR];
  logic [N_SPR-1:0]        r_sh_vis;
  logic signed [COORD_W:0] r_act_left [N_SPR];
  logic signed [COORD_W:0] r_act_upper[N_SPR];
  logic [N_SPR-1:0]        r_act_vis;

  logic signed [COORD_W:0] w_nx_left  [N_SPR];
  logic signed [COORD_W:0] w_nx_upper [N_SPR];
  logic [N_SPR-1:0]        w_nx_vis;

  // Shadow contents after this cycle's write, so a swap on the same edge sees it
  always_comb begin
    w_nx_left  = r_sh_left;
    w_nx_upper = r_sh_upper;
    w_nx_vis   = r_sh_vis;
    for (int i = 0; i < N_SPR; i++) begin
      if (pos_we && pos_idx == IDX_W'(i)) begin
        w_nx_left[i]  = $signed(pos_left);
        w_nx_upper[i] = $signed(pos_upper);
        w_nx_vis[i]   = pos_vis;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < N_SPR; i++) begin
        r_sh_left[i]   <= '0;
        r_sh_upper[i]  <= '0;
        r_act_left[i]  <= '0;
        r_act_upper[i] <= '0;
      end
      r_sh_vis  <= '0;
      r_act_vis <= '0;
    end else begin
      r_sh_left  <= w_nx_left;
      r_sh_upper <= w_nx_upper;
      r_sh_vis   <= w_nx_vis;
      if (frame_sync) begin
        r_act_left  <= w_nx_left;
        r_act_upper <= w_nx_upper;
        r_act_vis   <= w_nx_vis;
      end
    end
  end

  logic signed [DIFF_W-1:0] w_dx[N_SPR];
  logic signed [DIFF_W-1:0] w_dy[N_SPR];
  logic [N_SPR-1:0]         w_hit;

  // Widened signed differences so negative offsets can never wrap into range
  always_comb begin
    for (int i = 0; i < N_SPR; i++) begin
      w_dx[i]  = $signed({2'b00, DrawX}) - $signed({r_act_left[i][COORD_W], r_act_left[i]});
      w_dy[i]  = $signed({2'b00, DrawY}) - $signed({r_act_upper[i][COORD_W], r_act_upper[i]});
      w_hit[i] = r_act_vis[i]
               && !w_dx[i][DIFF_W-1] && (w_dx[i] <= $signed(DIFF_W'(SPR_W-1)))
               && !w_dy[i][DIFF_W-1] && (w_dy[i] <= $signed(DIFF_W'(SPR_H-1)));
    end
  end

  logic [N_SPR-1:0] r_hit_p1;
  logic [DX_W-1:0]  r_dx_p1[N_SPR];
  logic [DY_W-1:0]  r_dy_p1[N_SPR];
  logic             r_vld_p1;

  // Stage 1: per-slot hit flags and in-sprite offsets
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_vld_p1 <= 1'b0;
      r_hit_p1 <= '0;
      for (int i = 0; i < N_SPR; i++) begin
        r_dx_p1[i] <= '0;
        r_dy_p1[i] <= '0;
      end
    end else begin
      r_vld_p1 <= pix_valid;
      r_hit_p1 <= pix_valid ? w_hit : '0;
      for (int i = 0; i < N_SPR; i++) begin
        r_dx_p1[i] <= w_dx[i][DX_W-1:0];
        r_dy_p1[i] <= w_dy[i][DY_W-1:0];
      end
    end
  end

  logic              w_sel_hit;
  logic [IDX_W-1:0]  w_sel_idx;
  logic [ADDR_W-1:0] w_sel_addr;

  // Scan from the top so the lowest hitting slot is the one left standing
  always_comb begin
    w_sel_hit  = 1'b0;
    w_sel_idx  = '0;
    w_sel_addr = '0;
    for (int i = N_SPR-1; i >= 0; i--) begin
      if (r_hit_p1[i]) begin
        w_sel_hit  = 1'b1;
        w_sel_idx  = IDX_W'(i);
        w_sel_addr = ADDR_W'(r_dx_p1[i]) + ADDR_W'(r_dy_p1[i]) * ADDR_W'(SPR_W);
      end
    end
  end

  logic              r_vld_p2;
  logic              r_hit_p2;
  logic [IDX_W-1:0]  r_idx_p2;
  logic [ADDR_W-1:0] r_addr_p2;

  // Stage 2: priority winner and ROM address
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_vld_p2  <= 1'b0;
      r_hit_p2  <= 1'b0;
      r_idx_p2  <= '0;
      r_addr_p2 <= '0;
    end else begin
      r_vld_p2  <= r_vld_p1;
      r_hit_p2  <= w_sel_hit;
      r_idx_p2  <= w_sel_idx;
      r_addr_p2 <= w_sel_addr;
    end
  end

  assign out_valid = r_vld_p2;
  assign hit       = r_hit_p2;
  assign hit_idx   = r_idx_p2;
  assign addra     = r_addr_p2;

endmodule
